// File: rtl/intra_pkg.sv
// Shared definitions for the intra prediction/reconstruction blocks: default
// geometry, the FSM state encoding and the flat-packing index helper.
package intra_pkg;

    localparam int PIX_W_DEF   = 8;
    localparam int MB_SIZE_DEF = 16;

    // Encoding is shared with the encoder-side predictors; keep values fixed.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECON = 2'd1,
        DONE  = 2'd2
    } intra_state_t;

    // Pixel index of (row r, column c) inside a flat macroblock vector.
    function automatic int pix_index(input int r, input int c, input int mb);
        return r * mb + c;
    endfunction

endpackage

// File: rtl/intra_row_adder.sv
// Combinational MB_SIZE-lane adder: recon = residual + top, modulo 2^PIX_W.
module intra_row_adder
    import intra_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int MB_SIZE = MB_SIZE_DEF
) (
    input  logic [MB_SIZE*PIX_W-1:0] top_row,
    input  logic [MB_SIZE*PIX_W-1:0] residual_row,
    output logic [MB_SIZE*PIX_W-1:0] recon_row
);

    // Carry is dropped on purpose: this undoes the encoder's wrapping subtract.
    function automatic logic [PIX_W-1:0] wrap_add(input logic [PIX_W-1:0] a,
                                                  input logic [PIX_W-1:0] b);
        return a + b;
    endfunction

    always_comb begin
        recon_row = '0;
        for (int c = 0; c < MB_SIZE; c++) begin
            recon_row[c*PIX_W +: PIX_W] = wrap_add(top_row[c*PIX_W +: PIX_W],
                                                   residual_row[c*PIX_W +: PIX_W]);
        end
    end

endmodule

// File: rtl/intra_v_reconstruct.sv
// Vertical intra reconstruction, one row per cycle. Optional per-row output
// stream is enabled with the INTRA_V_ROW_STREAM_EN macro.
module intra_v_reconstruct
    import intra_pkg::*;
#(
    parameter int PIX_W   = PIX_W_DEF,
    parameter int MB_SIZE = MB_SIZE_DEF
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [MB_SIZE*PIX_W-1:0]           top_sample_flat,
    input  logic [MB_SIZE*MB_SIZE*PIX_W-1:0]   residual_flat,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [MB_SIZE*MB_SIZE*PIX_W-1:0]   recon_flat,
    output logic [MB_SIZE*PIX_W-1:0]           bottom_row_flat
`ifdef INTRA_V_ROW_STREAM_EN
    ,
    output logic                               row_valid,
    output logic [MB_SIZE*PIX_W-1:0]           row_data
`endif
);

    localparam int ROW_BITS = MB_SIZE * PIX_W;
    localparam int MB_BITS  = MB_SIZE * ROW_BITS;
    localparam int ROW_W    = (MB_SIZE > 1) ? $clog2(MB_SIZE) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MB_SIZE - 1);

    intra_state_t        state_q, state_d;
    logic [ROW_W-1:0]    row_q;
    logic [ROW_BITS-1:0] top_q;
    logic [MB_BITS-1:0]  res_q;
    logic [MB_BITS-1:0]  recon_q;
    logic [ROW_BITS-1:0] bottom_q;
    logic [ROW_BITS-1:0] res_row;
    logic [ROW_BITS-1:0] sum_row;
    logic                row_last;

    assign row_last        = (row_q == LAST_ROW);
    assign in_ready        = (state_q == IDLE);
    assign out_valid       = (state_q == DONE);
    assign recon_flat      = recon_q;
    assign bottom_row_flat = bottom_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = RECON;
            RECON:   if (row_last)  state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row mux: constant-offset selects keep the index arithmetic out of synthesis.
    always_comb begin
        res_row = '0;
        for (int r = 0; r < MB_SIZE; r++) begin
            if (int'(row_q) == r)
                res_row = res_q[pix_index(r, 0, MB_SIZE)*PIX_W +: ROW_BITS];
        end
    end

    intra_row_adder #(
        .PIX_W   (PIX_W),
        .MB_SIZE (MB_SIZE)
    ) u_row_adder (
        .top_row      (top_q),
        .residual_row (res_row),
        .recon_row    (sum_row)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            row_q    <= '0;
            top_q    <= '0;
            res_q    <= '0;
            recon_q  <= '0;
            bottom_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        top_q <= top_sample_flat;
                        res_q <= residual_flat;
                        row_q <= '0;
                    end
                end
                RECON: begin
                    for (int r = 0; r < MB_SIZE; r++) begin
                        if (int'(row_q) == r)
                            recon_q[pix_index(r, 0, MB_SIZE)*PIX_W +: ROW_BITS] <= sum_row;
                    end
                    row_q <= row_last ? '0 : row_q + 1'b1;
                    if (row_last)
                        bottom_q <= sum_row;
                end
                default: ;
            endcase
        end
    end

`ifdef INTRA_V_ROW_STREAM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row_valid <= 1'b0;
            row_data  <= '0;
        end else begin
            row_valid <= (state_q == RECON);
            if (state_q == RECON)
                row_data <= sum_row;
        end
    end
`endif

endmodule

// File: tb/tb_intra_v_reconstruct.sv
// Directed self-checking bench for intra_v_reconstruct (16x16, 8-bit pixels).
module tb_intra_v_reconstruct;

    localparam int PW  = 8;
    localparam int MB  = 16;
    localparam int RB  = MB * PW;
    localparam int MBB = MB * RB;

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [RB-1:0]  top_sample_flat;
    logic [MBB-1:0] residual_flat;
    logic           out_valid;
    logic           out_ready;
    logic [MBB-1:0] recon_flat;
    logic [RB-1:0]  bottom_row_flat;
`ifdef INTRA_V_ROW_STREAM_EN
    logic           row_valid;
    logic [RB-1:0]  row_data;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    intra_v_reconstruct #(.PIX_W(PW), .MB_SIZE(MB)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .top_sample_flat (top_sample_flat),
        .residual_flat   (residual_flat),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .recon_flat      (recon_flat),
        .bottom_row_flat (bottom_row_flat)
`ifdef INTRA_V_ROW_STREAM_EN
        ,
        .row_valid       (row_valid),
        .row_data        (row_data)
`endif
    );

    // First differing pixel, used only to keep failure lines short.
    function automatic int first_diff(input logic [MBB-1:0] a, input logic [MBB-1:0] b);
        for (int i = 0; i < MB*MB; i++)
            if (a[i*PW +: PW] !== b[i*PW +: PW]) return i;
        return 0;
    endfunction

    task automatic do_job(input logic [RB-1:0] t, input logic [MBB-1:0] r, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        top_sample_flat = t;
        residual_flat   = r;
        in_valid        = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        if (!out_valid) lat = -1;
    endtask

    task automatic release_out();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_cmp++; if (recon_flat !== '0) begin n_bad++; $display("FAIL reset_recon: pixel %0d nonzero", first_diff(recon_flat, '0)); end
        n_cmp++; if (bottom_row_flat !== '0) begin n_bad++; $display("FAIL reset_bottom: got %h expected 0", bottom_row_flat); end
`ifdef INTRA_V_ROW_STREAM_EN
        n_cmp++; if (row_valid !== 1'b0) begin n_bad++; $display("FAIL reset_row_valid: got %b expected 0", row_valid); end
`endif
    endtask

    task automatic test_zero_residual();
        logic [RB-1:0]  t;
        logic [MBB-1:0] exp_r;
        int lat, i;
        for (int c = 0; c < MB; c++) t[c*PW +: PW] = 8'(c * 16);
        exp_r = {MB{t}};
        do_job(t, '0, lat);
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL zero_latency: got %0d expected 16", lat); end
        n_cmp++; if (recon_flat !== exp_r) begin n_bad++; i = first_diff(recon_flat, exp_r);
            $display("FAIL zero_recon: pixel %0d got %h expected %h", i, recon_flat[i*PW +: PW], exp_r[i*PW +: PW]); end
        n_cmp++; if (bottom_row_flat !== t) begin n_bad++; $display("FAIL zero_bottom: got %h expected %h", bottom_row_flat, t); end
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL zero_in_ready_done: got %b expected 0", in_ready); end
        release_out();
        n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL zero_release_valid: got %b expected 0", out_valid); end
        n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL zero_release_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_wrap();
        int lat, i;
        do_job({MB{8'hF0}}, {MB*MB{8'h20}}, lat);
        n_cmp++; if (recon_flat !== {MB*MB{8'h10}}) begin n_bad++; i = first_diff(recon_flat, {MB*MB{8'h10}});
            $display("FAIL wrap_f0_20: pixel %0d got %h expected 10", i, recon_flat[i*PW +: PW]); end
        n_cmp++; if (bottom_row_flat !== {MB{8'h10}}) begin n_bad++; $display("FAIL wrap_f0_20_bottom: got %h expected %h", bottom_row_flat, {MB{8'h10}}); end
        release_out();
        do_job('0, {MB*MB{8'hFF}}, lat);
        n_cmp++; if (recon_flat !== {MB*MB{8'hFF}}) begin n_bad++; i = first_diff(recon_flat, {MB*MB{8'hFF}});
            $display("FAIL wrap_00_ff: pixel %0d got %h expected ff", i, recon_flat[i*PW +: PW]); end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL wrap_latency: got %0d expected 16", lat); end
        release_out();
    endtask

    task automatic test_round_trip();
        logic [RB-1:0]  t;
        logic [MBB-1:0] p, r;
        logic [PW-1:0]  pb, tb;
        int lat, i;
        for (int n = 0; n < 20; n++) begin
            for (int c = 0; c < MB; c++) t[c*PW +: PW] = 8'($urandom_range(0, 255));
            for (int k = 0; k < MB*MB; k++) begin
                pb = 8'($urandom_range(0, 255));
                tb = t[(k % MB)*PW +: PW];
                p[k*PW +: PW] = pb;
                r[k*PW +: PW] = pb - tb;
            end
            do_job(t, r, lat);
            n_cmp++; if (recon_flat !== p) begin n_bad++; i = first_diff(recon_flat, p);
                $display("FAIL round_trip_%0d: pixel %0d got %h expected %h", n, i, recon_flat[i*PW +: PW], p[i*PW +: PW]); end
            n_cmp++; if (bottom_row_flat !== p[MBB-1 -: RB]) begin n_bad++;
                $display("FAIL round_trip_bottom_%0d: got %h expected %h", n, bottom_row_flat, p[MBB-1 -: RB]); end
            release_out();
        end
    endtask

    task automatic test_backpressure();
        logic [RB-1:0]  t;
        logic [MBB-1:0] r, exp_r;
        int lat, i;
        for (int c = 0; c < MB; c++) t[c*PW +: PW] = 8'(c);
        for (int rr = 0; rr < MB; rr++)
            for (int c = 0; c < MB; c++) begin
                r[(rr*MB + c)*PW +: PW]     = 8'(rr);
                exp_r[(rr*MB + c)*PW +: PW] = 8'(rr + c);
            end
        do_job(t, r, lat);
        @(negedge clk);
        top_sample_flat = {MB{8'h01}};
        residual_flat   = {MB*MB{8'h02}};
        in_valid        = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_bad++;
                $display("FAIL bp_hold_ctrl_%0d: got valid=%b ready=%b expected valid=1 ready=0", k, out_valid, in_ready); end
            n_cmp++; if (recon_flat !== exp_r || bottom_row_flat !== exp_r[MBB-1 -: RB]) begin n_bad++; i = first_diff(recon_flat, exp_r);
                $display("FAIL bp_hold_data_%0d: pixel %0d got %h expected %h", k, i, recon_flat[i*PW +: PW], exp_r[i*PW +: PW]); end
        end
        release_out();
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL bp_release: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_pending_accept: got in_ready=%b expected 0", in_ready); end
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk);
            lat++;
            #1;
        end
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL bp_pending_latency: got %0d expected 16", lat); end
        n_cmp++; if (recon_flat !== {MB*MB{8'h03}}) begin n_bad++; i = first_diff(recon_flat, {MB*MB{8'h03}});
            $display("FAIL bp_pending_recon: pixel %0d got %h expected 03", i, recon_flat[i*PW +: PW]); end
        release_out();
    endtask

    task automatic test_reset_mid();
        logic [RB-1:0]  t;
        logic [MBB-1:0] exp_r;
        int lat, i;
        @(negedge clk);
        top_sample_flat = {MB{8'h11}};
        residual_flat   = {MB*MB{8'h22}};
        in_valid        = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin n_bad++;
            $display("FAIL mid_reset_ctrl: got valid=%b ready=%b expected valid=0 ready=1", out_valid, in_ready); end
        n_cmp++; if (recon_flat !== '0 || bottom_row_flat !== '0) begin n_bad++;
            $display("FAIL mid_reset_data: pixel %0d got %h expected 00", first_diff(recon_flat, '0), recon_flat[first_diff(recon_flat, '0)*PW +: PW]); end
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < MB; c++) t[c*PW +: PW] = 8'(c);
        for (int k = 0; k < MB*MB; k++) exp_r[k*PW +: PW] = 8'((k % MB) + 5);
        do_job(t, {MB*MB{8'h05}}, lat);
        n_cmp++; if (lat !== 16) begin n_bad++; $display("FAIL mid_reset_new_latency: got %0d expected 16", lat); end
        n_cmp++; if (recon_flat !== exp_r) begin n_bad++; i = first_diff(recon_flat, exp_r);
            $display("FAIL mid_reset_new_recon: pixel %0d got %h expected %h", i, recon_flat[i*PW +: PW], exp_r[i*PW +: PW]); end
        release_out();
    endtask

    task automatic test_back_to_back();
        logic [RB-1:0]  ta;
        logic [MBB-1:0] ra, rb, ea, eb;
        int nacc, acc0, acc1, nrow, i;
        for (int c = 0; c < MB; c++) ta[c*PW +: PW] = 8'(c);
        for (int rr = 0; rr < MB; rr++)
            for (int c = 0; c < MB; c++) begin
                ra[(rr*MB + c)*PW +: PW] = 8'(rr * 16);
                rb[(rr*MB + c)*PW +: PW] = 8'(rr * 16 + c);
                ea[(rr*MB + c)*PW +: PW] = 8'(rr * 16 + c);
                eb[(rr*MB + c)*PW +: PW] = 8'(rr * 16 + c + 128);
            end
        nacc = 0; acc0 = -1; acc1 = -1; nrow = 0;
        @(negedge clk);
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (cyc > 0) @(negedge clk);
`ifdef INTRA_V_ROW_STREAM_EN
            if (row_valid) begin
                n_cmp++;
                if (nrow >= 32 || row_data !== ((nrow < 16) ? ea[(nrow % 16)*RB +: RB] : eb[(nrow % 16)*RB +: RB])) begin
                    n_bad++;
                    $display("FAIL b2b_row_%0d: got %h expected %h", nrow, row_data,
                             (nrow < 16) ? ea[(nrow % 16)*RB +: RB] : eb[(nrow % 16)*RB +: RB]);
                end
                nrow++;
            end
`endif
            if (in_ready && nacc < 2) begin
                if (nacc == 0) begin acc0 = cyc; top_sample_flat = ta; residual_flat = ra; end
                else begin acc1 = cyc; top_sample_flat = {MB{8'h80}}; residual_flat = rb; end
                in_valid = 1'b1;
                nacc++;
            end else if (in_ready) begin
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n_cmp++; if (nacc !== 2 || acc1 - acc0 !== 18) begin n_bad++;
            $display("FAIL b2b_spacing: got %0d acceptances %0d cycles apart expected 2 and 18", nacc, acc1 - acc0); end
        n_cmp++; if (recon_flat !== eb) begin n_bad++; i = first_diff(recon_flat, eb);
            $display("FAIL b2b_second_recon: pixel %0d got %h expected %h", i, recon_flat[i*PW +: PW], eb[i*PW +: PW]); end
`ifdef INTRA_V_ROW_STREAM_EN
        n_cmp++; if (nrow !== 32) begin n_bad++; $display("FAIL b2b_row_count: got %0d expected 32", nrow); end
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset           = 1'b1;
        in_valid        = 1'b0;
        out_ready       = 1'b0;
        top_sample_flat = '0;
        residual_flat   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        test_reset();
        test_zero_residual();
        test_wrap();
        test_round_trip();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/intra_v_reconstruct.md
Name: intra_v_reconstruct

Overview:
- Decoder-side counterpart of the vertical intra predictor.
- Takes a 16x16 residual macroblock plus the 16 top neighbour samples, and rebuilds the pixels as recon[r][c] = residual[r][c] + top[c] (mod 2^PIX_W).
- Processes one row per cycle, with valid/ready handshakes on input and output.
- Exports the reconstructed bottom row so it can serve as the top sample for the next macroblock below.

Parameters:
- PIX_W, 8, bits per pixel/residual sample.
- MB_SIZE, 16, macroblock edge length in pixels; rows and columns both.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  top_sample_flat and residual_flat are valid.
- in_ready  output  1  block can accept a macroblock (high only in IDLE).
- top_sample_flat  input  MB_SIZE*PIX_W  top sample for column c at bits [PIX_W*c +: PIX_W].
- residual_flat  input  MB_SIZE*MB_SIZE*PIX_W  residual for (row r, column c) at bits [PIX_W*(r*MB_SIZE+c) +: PIX_W].
- out_valid  output  1  recon_flat and bottom_row_flat hold a complete macroblock.
- out_ready  input  1  consumer accepts the output.
- recon_flat  output  MB_SIZE*MB_SIZE*PIX_W  reconstructed pixels, same packing as residual_flat.
- bottom_row_flat  output  MB_SIZE*PIX_W  copy of recon row MB_SIZE-1, same packing as top_sample_flat.

Behaviour:
- Reset: reset, asynchronous, active-high; clock clk. On reset:
  - state=IDLE, row counter=0.
  - in_ready=1, out_valid=0.
  - recon_flat=0, bottom_row_flat=0.
  - Internal top and residual registers are cleared.
  - Reset mid-job drops the job; no partial output is flagged.
- States: IDLE, RECON, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1, capture top_sample_flat and residual_flat into internal registers, set row=0, in_ready=0, go to RECON.
- RECON:
  - Each edge writes row `row` of recon_flat from the captured registers, then row increments.
  - The edge that writes row MB_SIZE-1 also loads bottom_row_flat with that row, sets out_valid=1, and goes to DONE.
  - Exactly MB_SIZE edges are spent in RECON; in_valid is ignored.
- DONE:
  - recon_flat and bottom_row_flat are held stable while out_valid=1.
  - On an edge with out_ready=1: out_valid=0, in_ready=1, go to IDLE.
  - No input is accepted in the same cycle as output release.
- Latency: if acceptance happens at edge E0, out_valid rises at edge E0+MB_SIZE (E16 by default).
- Throughput: one macroblock per MB_SIZE+2 cycles with out_ready held at 1.
- Arithmetic:
  - Unsigned PIX_W-bit addition; the carry is discarded (wrap-around).
  - This is the exact inverse of the encoder's mod-2^PIX_W subtraction.
  - No saturation.
- Intermediate recon_flat contents during RECON are undefined to consumers; only values qualified by out_valid are meaningful.
- in_valid asserted during RECON or DONE is not consumed; the upstream holds it until in_ready.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: INTRA_V_ROW_STREAM_EN.
- When defined, two extra outputs are added:
  - row_valid (1 bit): high for one cycle after each RECON edge.
  - row_data (MB_SIZE*PIX_W bits): the row just written.
  - Rows are emitted in order 0..MB_SIZE-1, with no backpressure.
  - Both outputs reset to 0.
- When undefined, these ports and their logic are absent, and the block behaviour is otherwise identical.

Decomposition:
- Shared package intra_pkg holds:
  - PIX_W and MB_SIZE defaults.
  - State encoding constants (IDLE=0, RECON=1, DONE=2), shared with the encoder-side predictors.
  - Pixel-index helper constants for the flat packing.
- One natural sub-module, intra_row_adder: purely combinational MB_SIZE-lane PIX_W-bit wrap adder (residual row + top row → recon row), instantiated once and fed by the row mux.

Test Plan:
- Zero residual: top[c]=c*16, residual all 0 → every recon row equals top; bottom_row_flat=top; out_valid rises 16 edges after acceptance.
- Wrap-around: top all 0xF0, residual all 0x20 → recon all 0x10. Top 0x00, residual 0xFF → 0xFF.
- Round trip: random pixels P and top T; encoder residual (P-T mod 256) fed in → recon_flat equals P bit-exactly; 20 random macroblocks.
- Backpressure: out_ready low for 10 cycles after out_valid → outputs held stable, in_ready=0, a pending in_valid is not consumed. Raising out_ready → release, then in_ready=1 on the next cycle.
- Reset mid-job: assert reset at row 7 → immediately out_valid=0, in_ready=1, recon_flat=0. A new job afterwards completes correctly.
- Back-to-back with the macro defined: in_valid and out_ready held high, two macroblocks → 16 row_valid pulses each, rows 0..15 in order, second acceptance 18 cycles after the first.
